// File: rtl/rv32m_ctrl.sv
// rv32m_ctrl - issue-side controller for the iterative RV32M multiply/divide unit.
//
// Takes one M-extension op from execute, resolves divide-by-zero and signed
// overflow locally, otherwise issues it to the unit via a single-cycle start
// pulse and waits for the level finish. A watchdog aborts a hung unit. The
// result is returned with a valid/ready handshake. Every output is a flop.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake
//   req_funct3, req_a, req_b       RV32M funct3 and operands
//   req_rd                         destination register tag
//   flush                          cancel any in-flight operation
//   mdu_start, mdu_a, mdu_b, mdu_m start pulse, operands and opcode to the unit
//   mdu_finish, mdu_r              unit done (level) and its result
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_rd, rsp_err      result, tag, watchdog-abort flag
//
// state | meaning
// IDLE  | ready for a request; with pend set, the latched op is being decoded
// ISSUE | start pulse is on the unit for this one cycle
// WAIT  | waiting for finish, watchdog counting
// RESP  | result presented until rsp_ready

module rv32m_ctrl #(
    parameter int TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        mdu_start,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    output logic [2:0]  mdu_m,
    input  logic        mdu_finish,
    input  logic [31:0] mdu_r,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_nx;
    logic              pend_q, pend_nx;
    logic [WD_W-1:0]   wd_q, wd_nx;
    logic [31:0]       data_nx;
    logic              err_nx;
    logic              accept;
    logic              div_op;
    logic              b_zero;
    logic              ovf;

    // Corner cases are decided from the latched operands during the pend
    // cycle, which keeps the 32-bit compares off the request input path.
    always_comb begin
        accept   = (state_q == S_IDLE) && !pend_q && req_ready && req_valid && !flush;
        div_op   = mdu_m[2];
        b_zero   = (mdu_b == 32'h0000_0000);
        ovf      = !mdu_m[0] && (mdu_a == 32'h8000_0000) && (mdu_b == 32'hFFFF_FFFF);

        state_nx = state_q;
        pend_nx  = pend_q;
        wd_nx    = wd_q;
        data_nx  = rsp_data;
        err_nx   = rsp_err;

        if (flush) begin
            state_nx = S_IDLE;
            pend_nx  = 1'b0;
            err_nx   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        pend_nx = 1'b1;
                    end else if (pend_q) begin
                        pend_nx = 1'b0;
                        if (div_op && b_zero) begin
                            state_nx = S_RESP;
                            data_nx  = mdu_m[1] ? mdu_a : 32'hFFFF_FFFF;
                            err_nx   = 1'b0;
                        end else if (div_op && ovf) begin
                            state_nx = S_RESP;
                            data_nx  = mdu_m[1] ? 32'h0000_0000 : 32'h8000_0000;
                            err_nx   = 1'b0;
                        end else begin
                            state_nx = S_ISSUE;
                        end
                    end
                end
                // finish is ignored here: it may still be high from the previous op
                S_ISSUE: begin
                    state_nx = S_WAIT;
                    wd_nx    = '0;
                end
                S_WAIT: begin
                    if (mdu_finish) begin
                        state_nx = S_RESP;
                        data_nx  = mdu_r;
                        err_nx   = 1'b0;
                    end else if (wd_q == WD_W'(TIMEOUT)) begin
                        state_nx = S_RESP;
                        data_nx  = 32'h0000_0000;
                        err_nx   = 1'b1;
                    end else begin
                        wd_nx = wd_q + WD_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_nx = S_IDLE;
                        err_nx   = 1'b0;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    pend_nx  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pend_q    <= 1'b0;
            wd_q      <= '0;
            req_ready <= 1'b0;
            mdu_start <= 1'b0;
            mdu_a     <= 32'h0000_0000;
            mdu_b     <= 32'h0000_0000;
            mdu_m     <= 3'b000;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0000_0000;
            rsp_rd    <= 5'd0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_nx;
            pend_q    <= pend_nx;
            wd_q      <= wd_nx;
            rsp_data  <= data_nx;
            rsp_err   <= err_nx;
            // Outputs are registered copies of the next-state decode.
            req_ready <= (state_nx == S_IDLE) && !pend_nx;
            mdu_start <= (state_nx == S_ISSUE);
            rsp_valid <= (state_nx == S_RESP);
            if (accept) begin
                mdu_a  <= req_a;
                mdu_b  <= req_b;
                mdu_m  <= req_funct3;
                rsp_rd <= req_rd;
            end
        end
    end

endmodule

// File: tb/tb_rv32m_ctrl.sv
// Directed bench for rv32m_ctrl. The unit is modelled inline by driving
// mdu_finish/mdu_r at the cycle counts each step calls for.

module tb_rv32m_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_a = 32'h0;
    logic [31:0] req_b = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        flush = 1'b0;
    logic        mdu_start;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic [2:0]  mdu_m;
    logic        mdu_finish = 1'b0;
    logic [31:0] mdu_r = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int valid_seen = 0;
    logic watch_valid = 1'b0;

    rv32m_ctrl #(.TIMEOUT(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rd     (req_rd),
        .flush      (flush),
        .mdu_start  (mdu_start),
        .mdu_a      (mdu_a),
        .mdu_b      (mdu_b),
        .mdu_m      (mdu_m),
        .mdu_finish (mdu_finish),
        .mdu_r      (mdu_r),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mdu_start) start_cnt <= start_cnt + 1;
        if (watch_valid && rsp_valid) valid_seen <= valid_seen + 1;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns just after the acceptance edge.
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            tick(1);
            k++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_a      = a;
        req_b      = b;
        req_rd     = rd;
        tick(1);
        req_valid  = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk("hs_valid_drop", {31'b0, rsp_valid}, 32'd0);
        chk("hs_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int s0;
        logic [31:0] hold_data;

        // reset values
        tick(2);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_mdu_start", {31'b0, mdu_start}, 32'd0);
        chk("rst_mdu_a", mdu_a, 32'd0);
        chk("rst_mdu_m", {29'b0, mdu_m}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        chk("rel_req_ready_pre", {31'b0, req_ready}, 32'd0);
        tick(1);
        chk("rel_req_ready_post", {31'b0, req_ready}, 32'd1);

        // mul 7 * -3, unit finishes after 33 cycles
        s0 = start_cnt;
        send(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        chk("mul_req_ready_fall", {31'b0, req_ready}, 32'd0);
        chk("mul_no_start_e0", {31'b0, mdu_start}, 32'd0);
        tick(1);
        chk("mul_start_e1", {31'b0, mdu_start}, 32'd1);
        chk("mul_mdu_m", {29'b0, mdu_m}, 32'd0);
        chk("mul_mdu_a", mdu_a, 32'd7);
        chk("mul_mdu_b", mdu_b, 32'hFFFF_FFFD);
        tick(1);
        chk("mul_start_e2", {31'b0, mdu_start}, 32'd0);
        tick(31);
        chk("mul_valid_early", {31'b0, rsp_valid}, 32'd0);
        mdu_r = 32'hFFFF_FFEB;
        mdu_finish = 1'b1;
        tick(1);
        chk("mul_valid", {31'b0, rsp_valid}, 32'd1);
        chk("mul_data", rsp_data, 32'hFFFF_FFEB);
        chk("mul_err", {31'b0, rsp_err}, 32'd0);
        chk("mul_rd", {27'b0, rsp_rd}, 32'd5);
        chk("mul_start_count", start_cnt - s0, 32'd1);
        handshake();

        // divide by zero fast paths
        s0 = start_cnt;
        send(3'b101, 32'd100, 32'd0, 5'd3);
        chk("divu0_valid_e0", {31'b0, rsp_valid}, 32'd0);
        tick(1);
        chk("divu0_valid", {31'b0, rsp_valid}, 32'd1);
        chk("divu0_data", rsp_data, 32'hFFFF_FFFF);
        chk("divu0_rd", {27'b0, rsp_rd}, 32'd3);
        handshake();
        send(3'b111, 32'd100, 32'd0, 5'd4);
        tick(1);
        chk("remu0_valid", {31'b0, rsp_valid}, 32'd1);
        chk("remu0_data", rsp_data, 32'd100);
        handshake();

        // signed overflow fast paths
        send(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        tick(1);
        chk("divovf_valid", {31'b0, rsp_valid}, 32'd1);
        chk("divovf_data", rsp_data, 32'h8000_0000);
        handshake();
        send(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        tick(1);
        chk("removf_valid", {31'b0, rsp_valid}, 32'd1);
        chk("removf_data", rsp_data, 32'h0);
        chk("fast_no_start", start_cnt - s0, 32'd0);
        handshake();

        // stale finish: still high from the mul, through ISSUE
        mdu_r = 32'hDEAD_BEEF;
        send(3'b011, 32'd3, 32'd5, 5'd7);
        tick(1);
        chk("stale_start", {31'b0, mdu_start}, 32'd1);
        chk("stale_mdu_m", {29'b0, mdu_m}, 32'd3);
        tick(1);
        chk("stale_no_valid", {31'b0, rsp_valid}, 32'd0);
        mdu_finish = 1'b0;
        tick(31);
        chk("stale_valid_early", {31'b0, rsp_valid}, 32'd0);
        mdu_r = 32'h1234_5678;
        mdu_finish = 1'b1;
        tick(1);
        chk("stale_valid", {31'b0, rsp_valid}, 32'd1);
        chk("stale_data", rsp_data, 32'h1234_5678);
        chk("stale_rd", {27'b0, rsp_rd}, 32'd7);
        handshake();

        // watchdog: unit never finishes
        mdu_finish = 1'b0;
        send(3'b001, 32'd9, 32'd9, 5'd9);
        tick(2);
        tick(100);
        chk("wd_valid_early", {31'b0, rsp_valid}, 32'd0);
        tick(1);
        chk("wd_valid", {31'b0, rsp_valid}, 32'd1);
        chk("wd_err", {31'b0, rsp_err}, 32'd1);
        chk("wd_data", rsp_data, 32'd0);
        chk("wd_rd", {27'b0, rsp_rd}, 32'd9);
        hold_data = rsp_data;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("wd_hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("wd_hold_err", {31'b0, rsp_err}, 32'd1);
            chk("wd_hold_data", rsp_data, 32'd0);
        end
        handshake();
        chk("wd_err_clear", {31'b0, rsp_err}, 32'd0);

        // flush in WAIT coincident with finish
        watch_valid = 1'b1;
        send(3'b000, 32'd2, 32'd3, 5'd11);
        tick(2);
        tick(3);
        mdu_r = 32'd6;
        mdu_finish = 1'b1;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        mdu_finish = 1'b0;
        chk("flush_valid", {31'b0, rsp_valid}, 32'd0);
        chk("flush_req_ready", {31'b0, req_ready}, 32'd1);
        tick(3);

        // reset mid-WAIT on a second op
        send(3'b100, 32'd20, 32'd3, 5'd12);
        tick(2);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("midrst_mdu_a", mdu_a, 32'd0);
        chk("midrst_rd", {27'b0, rsp_rd}, 32'd0);
        chk("midrst_start", {31'b0, mdu_start}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("midrst_req_ready_back", {31'b0, req_ready}, 32'd1);
        tick(2);
        watch_valid = 1'b0;
        #1;
        chk("flush_rst_no_valid", valid_seen, 32'd0);

        // next op completes normally
        send(3'b110, 32'd20, 32'd3, 5'd13);
        tick(2);
        tick(4);
        mdu_r = 32'd2;
        mdu_finish = 1'b1;
        tick(1);
        chk("after_valid", {31'b0, rsp_valid}, 32'd1);
        chk("after_data", rsp_data, 32'd2);
        chk("after_rd", {27'b0, rsp_rd}, 32'd13);
        chk("after_err", {31'b0, rsp_err}, 32'd0);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32m_ctrl.md
# rv32m_ctrl

Issue-side controller for the iterative RV32M multiply/divide unit. Accepts one M-extension operation from the pipeline execute stage and drives the unit's level `start`/`finish` interface. Resolves RISC-V corner cases (divide by zero, signed overflow) without issuing to the unit, guards against a hung unit with a watchdog, and returns the result with a valid/ready handshake.

## Interface
- `TIMEOUT`, default 100: maximum WAIT cycles before the watchdog aborts the operation.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  operation request.
- `req_ready`  out  1  controller can accept a request.
- `req_funct3`  in  3  RV32M funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `req_a`, `req_b`  in  32  rs1 and rs2 values.
- `req_rd`  in  5  destination register tag.
- `flush`  in  1  cancel any in-flight operation.
- `mdu_start`  out  1  start pulse to the unit.
- `mdu_a`, `mdu_b`  out  32  operands to the unit.
- `mdu_m`  out  3  unit opcode; equals the latched funct3.
- `mdu_finish`  in  1  unit done, level-held until the next start.
- `mdu_r`  in  32  unit result.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  32  result.
- `rsp_rd`  out  5  destination tag.
- `rsp_err`  out  1  result was produced by a watchdog timeout.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch funct3, a, b, rd.
  - Fast path to RESP when the op is a divide and b==0: div/divu give 0xFFFFFFFF; rem/remu give a.
  - Fast path to RESP for div with a==0x80000000, b==0xFFFFFFFF: result 0x80000000. The same operands with rem give 0.
  - Otherwise go to ISSUE.
- ISSUE: one cycle; `mdu_start`=1 with operands and opcode driven from the latches. Next state is WAIT. Clear the watchdog counter.
- WAIT:
  - `mdu_start`=0; watchdog increments each cycle.
  - On `mdu_finish`=1: capture `mdu_r` into `rsp_data`, go to RESP.
  - If the watchdog reaches `TIMEOUT` before finish: `rsp_data`=0, `rsp_err`=1, go to RESP.
  - `mdu_finish` is never sampled in ISSUE. It can be stale-high from the previous op until the start edge.
- RESP:
  - `rsp_valid`=1; `rsp_data`, `rsp_rd`, `rsp_err` held stable.
  - On `rsp_ready`: go to IDLE and clear `rsp_err`.
- `mdu_a`, `mdu_b`, `mdu_m` always drive the latched values, so they are stable outside ISSUE.
- `flush`:
  - In any state, go to IDLE next cycle with `rsp_valid` dropped and no response.
  - `flush` takes priority over a simultaneous `mdu_finish`, `rsp_ready` or `req_valid`.
  - The unit may keep running; its later `finish` is ignored because the next request re-issues `start`.

## Timing
- Reset values: state IDLE, `req_ready`=0, `mdu_start`=0, `mdu_a`/`mdu_b`=0, `mdu_m`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_rd`=0, `rsp_err`=0, watchdog=0.
- `req_ready` is registered. It rises on the first clock edge after `rst_n` deasserts, and falls the edge after acceptance.
- Reset asserted mid-operation returns everything to reset values immediately. There is no response, and the unit is not touched.
- Request accepted at edge 0:
  - Fast path: `rsp_valid`=1 after edge 1.
  - Normal path: `mdu_start`=1 for exactly the cycle after edge 1, WAIT from edge 2, `rsp_valid` from the edge after the first WAIT cycle with `mdu_finish`=1.
- Back-to-back: after the `rsp_ready` handshake edge, `req_ready`=1 the next cycle. There is one idle cycle between operations.
- Watchdog: `rsp_err` response appears `TIMEOUT`+1 edges after entering WAIT with no finish.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- mul, a=7, b=-3 (0xFFFFFFFD); unit model finishes after 33 cycles -> `mdu_start` single-cycle pulse with `mdu_m`=000; `rsp_data`=0xFFFFFFEB, `rsp_err`=0, `rsp_rd` echoes the tag.
- divu, a=100, b=0 -> no `mdu_start`; `rsp_valid` one edge after accept, `rsp_data`=0xFFFFFFFF. remu with the same operands -> `rsp_data`=100.
- div, a=0x80000000, b=0xFFFFFFFF -> fast path, `rsp_data`=0x80000000. rem with the same operands -> 0.
- Stale finish: `mdu_finish` held at 1 from the prior op through ISSUE, dropped after the start edge, raised 32 cycles later with `mdu_r`=0x12345678 -> response carries 0x12345678, not the stale value.
- Unit model never finishes, `TIMEOUT`=100 -> `rsp_valid` with `rsp_err`=1, `rsp_data`=0, 101 edges after entering WAIT. `rsp_ready` held low for 5 cycles -> outputs stay stable.
- `flush` in WAIT coincident with `mdu_finish`; then `rst_n` pulsed mid-WAIT on a second op -> `rsp_valid` never rises; `req_ready` returns, and the next op completes correctly.
